uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- 8N1 UART receiver that deserialises the DE2 RS-232 RXD line into bytes.
- Sits directly upstream of the string transmitter.
- Drives the byte/strobe pair the string transmitter buffers, one character at a time, until a 0x00 terminator arrives.
- Adds input synchronisation, mid-bit sampling, start-glitch rejection and framing-error detection.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), clocks per bit; overridable directly for simulation; must be >= 8.

Ports:
- i_Clk  input  1  system clock, all logic on rising edge.
- i_Rst  input  1  asynchronous active-low reset.
- i_rxd  input  1  raw serial line, idle high, asynchronous to i_Clk.
- o_rx_data  output  8  last correctly framed byte, LSB received first.
- o_rx_end  output  1  one-cycle strobe: o_rx_data is newly valid.
- o_rx_busy  output  1  high while a frame is being received (any state except IDLE).
- o_frame_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset (i_Rst=0, asynchronous):
  - o_rx_data=8'h00, o_rx_end=0, o_rx_busy=0, o_frame_err=0.
  - State IDLE, counters 0, synchroniser flops set to 1 (line idle).
- Reset mid-frame aborts the frame immediately; no strobe is produced.
- Synchroniser: i_rxd passes through 2 flops; only the synchronised value (rxd_s) is used. Detection latency is 2 cycles.
- Bit counter clk_cnt: 0..CLKS_PER_BIT-1. Bit index bit_idx: 0..7. Shift register rx_shift: 8 bits.
- IDLE: rxd_s=0 -> START, clk_cnt=0.
- START: counts to HALF=(CLKS_PER_BIT/2)-1, then samples rxd_s.
  - rxd_s=0 -> DATA, clk_cnt=0, bit_idx=0.
  - rxd_s=1 -> glitch, back to IDLE with no strobes.
- DATA: when clk_cnt reaches CLKS_PER_BIT-1, sample rxd_s into rx_shift[bit_idx] (LSB first) and reset clk_cnt.
  - After bit_idx=7 is sampled -> STOP; otherwise bit_idx+1.
- STOP: when clk_cnt reaches CLKS_PER_BIT-1, sample rxd_s.
  - 1 -> o_rx_data<=rx_shift and o_rx_end=1 for exactly the next cycle; go to IDLE.
  - 0 -> o_frame_err=1 for exactly the next cycle; o_rx_data unchanged; go to BREAK.
- BREAK: wait until rxd_s=1, then IDLE. A held-low line (break condition) therefore yields a single error and no phantom bytes.
- o_rx_end and o_frame_err are never high in the same cycle.
- o_rx_data is stable between o_rx_end strobes.
- The consumer may edge-detect o_rx_end. The strobe is one cycle, so a level-based "got it" latch in the consumer sees exactly one rising edge per byte.
- Back-to-back frames: the next start bit is accepted the first cycle IDLE sees rxd_s=0. Because the stop is sampled mid-bit, half a bit of slack remains before the next frame.
- Latency: o_rx_end rises 2 + 1 + HALF + 9*CLKS_PER_BIT + 1 cycles after the falling edge of i_rxd (±1 for synchroniser phase).
- Tolerated baud mismatch: up to ±4% combined, from centre sampling.
- No FIFO and no overrun detection: each new byte overwrites o_rx_data. The string transmitter consumes within one cycle, so this is sufficient.

Test Plan:
- Reset, then idle line: CLKS_PER_BIT=16, i_rxd=1 for 500 cycles -> all outputs 0, o_rx_data=8'h00.
- Single byte 0x41 ('A'), CLKS_PER_BIT=16 -> exactly one o_rx_end pulse, 1 cycle wide, o_rx_data=8'h41 at pulse, o_frame_err never high, pulse within ±1 cycle of computed latency (2+1+7+144+1=155).
- String "Hi" then 0x00 sent back-to-back with a single stop bit each -> three o_rx_end pulses with data 0x48, 0x69, 0x00 in order; o_rx_busy low only between frames.
- Start glitch: i_rxd low for 4 cycles (< HALF) then high -> returns to IDLE, no o_rx_end, no o_frame_err; then a valid 0x55 frame is received correctly.
- Framing error: frame for 0xA5 with stop bit driven 0 and line held low 40 more cycles -> one o_frame_err pulse, no o_rx_end, o_rx_data keeps previous value; after the line goes high, a 0x3C frame is received with o_rx_end.
- Reset mid-frame: assert i_Rst low during DATA bit 4 of 0xFF -> outputs 0 immediately, no strobe; after release, the next full 0x12 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises the raw RXD line, samples each bit at its centre
// and emits one-cycle strobes for a correctly framed byte or a framing error.
module uart_rx_byte #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_rxd,
    output logic [7:0] o_rx_data,
    output logic       o_rx_end,
    output logic       o_rx_busy,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_end;
    logic             r_frame_err;
    logic             r_busy;
    logic             r_rxd_m;
    logic             r_rxd_s;
    logic             w_rxd_s;

    // Two-flop synchroniser, preset to the idle-high line level
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_rxd_m <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_rxd_m <= i_rxd;
            r_rxd_s <= r_rxd_m;
        end
    end

    assign w_rxd_s = r_rxd_s;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_end    <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_end    <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    if (!w_rxd_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    // A start bit that is no longer low at its centre was noise
                    if (r_clk_cnt == HALF) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        if (!w_rxd_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == LAST) begin
                        r_clk_cnt          <= '0;
                        r_shift[r_bit_idx] <= w_rxd_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_clk_cnt == LAST) begin
                        r_clk_cnt <= '0;
                        if (w_rxd_s) begin
                            r_rx_data <= r_shift;
                            r_rx_end  <= 1'b1;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Hold off until the line returns high so a break yields one error only
                    if (w_rxd_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_end    = r_rx_end;
    assign o_rx_busy   = r_busy;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: table of back-to-back frames plus hand-written corner sequences,
// with a scoreboard queue of expected bytes checked on every o_rx_end strobe.
module tb_uart_rx_byte;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_end;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] o_rx_data;
    logic       o_rx_end;
    logic       o_rx_busy;
    logic       o_frame_err;

    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_end = 0;
    int         n_err = 0;
    int         last_end_cyc = 0;
    logic       prev_end = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_byte #(
        .CLK_FREQ    (50000000),
        .BAUD_RATE   (115200),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_rxd      (rxd),
        .o_rx_data  (o_rx_data),
        .o_rx_end   (o_rx_end),
        .o_rx_busy  (o_rx_busy),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rx_end) begin
                n_end++;
                last_end_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_rx_end: got data %0h, no byte expected", o_rx_data);
                end else begin
                    chk("rx_data", {24'h0, o_rx_data}, {24'h0, exp_q.pop_front()});
                end
                chk("end_err_exclusive", {31'h0, o_frame_err}, 32'h0);
            end
            if (o_frame_err) n_err++;
            if (prev_end) chk("rx_end_width", {31'h0, o_rx_end}, 32'h0);
            if (prev_err) chk("frame_err_width", {31'h0, o_frame_err}, 32'h0);
        end
        prev_end = o_rx_end;
        prev_err = o_frame_err;
    end

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   c0, lat, e0, r0, exp_e, exp_r;

        vecs[0] = '{8'h48, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h69, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0};

        // Reset state and idle line
        #2 rst_n = 1'b0;
        #3;
        chk("reset_data", {24'h0, o_rx_data}, 32'h0);
        chk("reset_busy", {31'h0, o_rx_busy}, 32'h0);
        chk("reset_end", {31'h0, o_rx_end}, 32'h0);
        chk("reset_err", {31'h0, o_frame_err}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        chk("idle_data", {24'h0, o_rx_data}, 32'h0);
        chk("idle_busy", {31'h0, o_rx_busy}, 32'h0);
        chk("idle_end_count", n_end, 32'h0);
        chk("idle_err_count", n_err, 32'h0);

        // Single byte 'A' with latency and busy checks
        e0 = n_end;
        exp_q.push_back(8'h41);
        c0 = cyc;
        fork
            send_frame(8'h41, 1'b1);
            begin
                repeat (80) @(posedge clk);
                #1;
                chk("busy_mid_frame", {31'h0, o_rx_busy}, 32'h1);
            end
        join
        drain("drain_A");
        chk("A_end_count", n_end - e0, 32'h1);
        chk("A_err_count", n_err, 32'h0);
        lat = last_end_cyc - c0;
        n_vec++;
        if (lat < 154 || lat > 156) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, expected 155 +/-1", lat);
        end

        // Table of back-to-back frames
        e0 = n_end;
        r0 = n_err;
        exp_e = 0;
        exp_r = 0;
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].exp_end) exp_q.push_back(vecs[v].data);
            exp_e += int'(vecs[v].exp_end);
            exp_r += int'(vecs[v].exp_err);
            send_frame(vecs[v].data, vecs[v].stop);
            chk("busy_between_frames", {31'h0, o_rx_busy}, 32'h0);
        end
        drain("drain_table");
        chk("table_end_count", n_end - e0, exp_e);
        chk("table_err_count", n_err - r0, exp_r);

        // Start glitch shorter than half a bit, then a valid frame
        e0 = n_end;
        r0 = n_err;
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_end_count", n_end - e0, 32'h0);
        chk("glitch_err_count", n_err - r0, 32'h0);
        chk("glitch_busy", {31'h0, o_rx_busy}, 32'h0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        drain("drain_55");
        chk("after_glitch_end_count", n_end - e0, 32'h1);

        // Framing error with the line held low afterwards
        e0 = n_end;
        r0 = n_err;
        send_frame(8'hA5, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("ferr_err_count", n_err - r0, 32'h1);
        chk("ferr_end_count", n_end - e0, 32'h0);
        chk("ferr_data_kept", {24'h0, o_rx_data}, 32'h55);
        chk("ferr_busy_in_break", {31'h0, o_rx_busy}, 32'h1);
        rxd = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("ferr_busy_released", {31'h0, o_rx_busy}, 32'h0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        drain("drain_3C");
        chk("after_ferr_end_count", n_end - e0, 32'h1);
        chk("after_ferr_err_count", n_err - r0, 32'h1);

        // Reset during data bit 4 of 0xFF
        e0 = n_end;
        r0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd = 1'b1;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_data", {24'h0, o_rx_data}, 32'h0);
        chk("midrst_busy", {31'h0, o_rx_busy}, 32'h0);
        chk("midrst_end", {31'h0, o_rx_end}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("midrst_no_strobe", n_end - e0, 32'h0);
        chk("midrst_no_err", n_err - r0, 32'h0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        drain("drain_12");
        chk("after_rst_end_count", n_end - e0, 32'h1);
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
